decode_queue_stage: RTL

- Parametrised RV32I decode stage with an instruction queue, a register scoreboard and valid/ready handshakes on both sides.
- Sits between fetch and execute.
- Buffers fetched instructions, decodes the queue head, and blocks on RAW hazards using per-register pending-write counters instead of pipeline destination compares.
- Issues one decoded instruction per cycle into a registered output slot.

---
 rtl/decode_queue_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue_stage.sv
// RV32I decode stage: instruction queue, per-register pending-write scoreboard, registered issue slot.
// Define RV32M_EN to decode the RV32M multiply/divide group; otherwise those encodings are illegal.
package decode_queue_pkg;
  typedef enum logic [3:0] {
    NONE, MATH, LOAD, STORE, BRANCH, JAL, JALR, LUI, ENV
  } instr_type_t;

  typedef enum logic [2:0] {
    MEM_NONE, MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU
  } mem_type_t;

  typedef enum logic [4:0] {
    NO_OP, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    EQ, NE, LT, GE, LTU, GEU,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_op_t;

  function automatic logic is_writer(input instr_type_t t);
    return (t == MATH) || (t == LOAD) || (t == JAL) || (t == JALR) || (t == LUI);
  endfunction
endpackage

module decode_queue_stage
  import decode_queue_pkg::*;
#(
  parameter int QDEPTH   = 4,
  parameter int SB_CNT_W = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_addr,
  input  logic [31:0]                 in_instr,
  input  logic                        flush,
  input  logic                        wb_valid,
  input  logic [4:0]                  wb_dest,
  output logic [4:0]                  reg_rd1_reg,
  output logic [4:0]                  reg_rd2_reg,
  input  logic [31:0]                 reg_rd1_data,
  input  logic [31:0]                 reg_rd2_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_addr,
  output instr_type_t                 out_instr_type,
  output mem_type_t                   out_mem_type,
  output alu_op_t                     out_op,
  output logic [4:0]                  out_dest,
  output logic [31:0]                 out_src1,
  output logic [31:0]                 out_src2,
  output logic [31:0]                 out_rs1_data,
  output logic [31:0]                 out_rs2_data,
  output logic [31:0]                 out_imm,
  output logic                        illegal,
  output logic [$clog2(QDEPTH):0]     occupancy
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [SB_CNT_W:0] SB_MAX = {1'b0, {SB_CNT_W{1'b1}}};

  logic [31:0]         q_addr_reg  [QDEPTH];
  logic [31:0]         q_instr_reg [QDEPTH];
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic                illegal_reg;
  logic [SB_CNT_W-1:0] sb_cnt_reg [32];

  logic                out_valid_reg;
  logic [31:0]         out_addr_reg, out_src1_reg, out_src2_reg;
  logic [31:0]         out_rs1_data_reg, out_rs2_data_reg, out_imm_reg;
  instr_type_t         out_type_reg;
  mem_type_t           out_mem_reg;
  alu_op_t             out_op_reg;
  logic [4:0]          out_dest_reg;

  logic        head_valid, enq, issue, out_fire;
  logic [31:0] head_instr, head_addr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  instr_type_t d_type;
  mem_type_t   d_mem;
  alu_op_t     d_op;
  logic [4:0]  d_dest;
  logic [31:0] d_src1, d_src2, d_imm;
  logic        use_rs1, use_rs2;

  assign head_valid = (count_reg != '0);
  assign head_instr = q_instr_reg[rd_ptr_reg];
  assign head_addr  = q_addr_reg[rd_ptr_reg];
  assign opcode     = head_instr[6:0];
  assign rd         = head_instr[11:7];
  assign funct3     = head_instr[14:12];
  assign rs1        = head_instr[19:15];
  assign rs2        = head_instr[24:20];
  assign funct7     = head_instr[31:25];

  assign in_ready    = (count_reg < CW'(QDEPTH)) && !illegal_reg;
  assign enq         = in_valid && in_ready && !flush;
  assign reg_rd1_reg = rs1;
  assign reg_rd2_reg = rs2;

  // Queue storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr_reg[wr_ptr_reg]  <= in_addr;
      q_instr_reg[wr_ptr_reg] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq, issue})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    d_type  = NONE;
    d_mem   = MEM_NONE;
    d_op    = NO_OP;
    d_dest  = '0;
    d_src1  = '0;
    d_src2  = '0;
    d_imm   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin
        d_type = MATH; d_dest = rd; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_src1 = reg_rd1_data; d_src2 = reg_rd2_data;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: d_op = ADD;  3'd1: d_op = SLL;
            3'd2: d_op = SLT;  3'd3: d_op = SLTU;
            3'd4: d_op = XOR;  3'd5: d_op = SRL;
            3'd6: d_op = OR;   default: d_op = AND;
          endcase
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'd0)      d_op = SUB;
          else if (funct3 == 3'd5) d_op = SRA;
        end
`ifdef RV32M_EN
        else if (funct7 == 7'h01) begin
          case (funct3)
            3'd0: d_op = MUL;   3'd1: d_op = MULH;
            3'd2: d_op = MULHSU; 3'd3: d_op = MULHU;
            3'd4: d_op = DIV;   3'd5: d_op = DIVU;
            3'd6: d_op = REM;   default: d_op = REMU;
          endcase
        end
`endif
      end
      7'b0010011: begin
        d_type = MATH; d_dest = rd; use_rs1 = 1'b1;
        d_src1 = reg_rd1_data;
        d_imm  = {{20{head_instr[31]}}, head_instr[31:20]};
        case (funct3)
          3'd0: d_op = ADD;  3'd2: d_op = SLT;  3'd3: d_op = SLTU;
          3'd4: d_op = XOR;  3'd6: d_op = OR;   3'd7: d_op = AND;
          3'd1: if (funct7 == 7'h00) d_op = SLL;
          default: begin
            if (funct7 == 7'h00)      d_op = SRL;
            else if (funct7 == 7'h20) d_op = SRA;
          end
        endcase
        // Shift amounts carry no funct7 bits into the operand.
        if (funct3 == 3'd1 || funct3 == 3'd5) d_imm = {27'd0, head_instr[24:20]};
        d_src2 = d_imm;
      end
      7'b0000011: begin
        d_type = LOAD; d_dest = rd; use_rs1 = 1'b1;
        d_imm  = {{20{head_instr[31]}}, head_instr[31:20]};
        d_src1 = reg_rd1_data; d_src2 = d_imm;
        case (funct3)
          3'd0: begin d_mem = MEM_B;  d_op = ADD; end
          3'd1: begin d_mem = MEM_H;  d_op = ADD; end
          3'd2: begin d_mem = MEM_W;  d_op = ADD; end
          3'd4: begin d_mem = MEM_BU; d_op = ADD; end
          3'd5: begin d_mem = MEM_HU; d_op = ADD; end
          default: d_op = NO_OP;
        endcase
      end
      7'b0100011: begin
        d_type = STORE; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_imm  = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        d_src1 = reg_rd1_data; d_src2 = d_imm;
        case (funct3)
          3'd0: begin d_mem = MEM_B; d_op = ADD; end
          3'd1: begin d_mem = MEM_H; d_op = ADD; end
          3'd2: begin d_mem = MEM_W; d_op = ADD; end
          default: d_op = NO_OP;
        endcase
      end
      7'b1100011: begin
        d_type = BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_imm  = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                  head_instr[30:25], head_instr[11:8], 1'b0};
        d_src1 = reg_rd1_data; d_src2 = reg_rd2_data;
        case (funct3)
          3'd0: d_op = EQ;  3'd1: d_op = NE;
          3'd4: d_op = LT;  3'd5: d_op = GE;
          3'd6: d_op = LTU; 3'd7: d_op = GEU;
          default: d_op = NO_OP;
        endcase
      end
      7'b0110111: begin
        d_type = LUI; d_dest = rd; d_op = ADD;
        d_imm  = {head_instr[31:12], 12'd0};
        d_src2 = d_imm;
      end
      7'b0010111: begin
        d_type = MATH; d_dest = rd; d_op = ADD;
        d_imm  = {head_instr[31:12], 12'd0};
        d_src1 = head_addr; d_src2 = d_imm;
      end
      7'b1101111: begin
        d_type = JAL; d_dest = rd; d_op = ADD;
        d_imm  = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                  head_instr[20], head_instr[30:21], 1'b0};
        d_src1 = head_addr; d_src2 = 32'd4;
      end
      7'b1100111: begin
        if (funct3 == 3'd0) begin
          d_type = JALR; d_dest = rd; d_op = ADD; use_rs1 = 1'b1;
          d_imm  = {{20{head_instr[31]}}, head_instr[31:20]};
          d_src1 = head_addr; d_src2 = 32'd4;
        end
      end
      7'b1110011: begin
        if (head_instr == 32'h0000_0073 || head_instr == 32'h0010_0073) begin
          d_type = ENV; d_op = ADD;
        end
      end
      default: d_op = NO_OP;
    endcase
    // Anything undecodable is presented as a blank NO_OP.
    if (d_op == NO_OP) begin
      d_type  = NONE;
      d_mem   = MEM_NONE;
      d_dest  = '0;
      d_src1  = '0;
      d_src2  = '0;
      d_imm   = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  logic                slot_writes;
  logic                rs1_busy, rs2_busy, slot_writes_rd, rd_full;
  logic [SB_CNT_W:0]   rd_pending;

  assign slot_writes = out_valid_reg && is_writer(out_type_reg);
  assign rs1_busy = use_rs1 && (rs1 != 5'd0) &&
                    ((sb_cnt_reg[rs1] != '0) || (slot_writes && out_dest_reg == rs1));
  assign rs2_busy = use_rs2 && (rs2 != 5'd0) &&
                    ((sb_cnt_reg[rs2] != '0) || (slot_writes && out_dest_reg == rs2));

  // The slot's writer is not yet counted, so include it to keep the counter from wrapping.
  assign slot_writes_rd = slot_writes && (out_dest_reg == d_dest);
  assign rd_pending     = {1'b0, sb_cnt_reg[d_dest]} + {{SB_CNT_W{1'b0}}, slot_writes_rd};
  assign rd_full        = (d_dest != 5'd0) && (rd_pending >= SB_MAX);

  assign issue = head_valid && !illegal_reg && (d_op != NO_OP) && !rs1_busy && !rs2_busy &&
                 !rd_full && (!out_valid_reg || out_ready) && !flush;
  assign out_fire = out_valid_reg && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal_reg <= 1'b0;
    else if (head_valid && d_op == NO_OP)
      illegal_reg <= 1'b1;
  end

  logic [31:0] sb_inc, sb_dec;

  for (genvar gi = 0; gi < 32; gi++) begin : g_sb
    assign sb_inc[gi] = out_fire && is_writer(out_type_reg) &&
                        (out_dest_reg == 5'(gi)) && (out_dest_reg != 5'd0);
    assign sb_dec[gi] = wb_valid && (wb_dest == 5'(gi)) && (wb_dest != 5'd0);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (!rst_n)
        sb_cnt_reg[i] <= '0;
      else if (sb_inc[i] && !sb_dec[i])
        sb_cnt_reg[i] <= sb_cnt_reg[i] + 1'b1;
      else if (sb_dec[i] && !sb_inc[i] && sb_cnt_reg[i] != '0)
        sb_cnt_reg[i] <= sb_cnt_reg[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg    <= 1'b0;
      out_addr_reg     <= '0;
      out_type_reg     <= NONE;
      out_mem_reg      <= MEM_NONE;
      out_op_reg       <= NO_OP;
      out_dest_reg     <= '0;
      out_src1_reg     <= '0;
      out_src2_reg     <= '0;
      out_rs1_data_reg <= '0;
      out_rs2_data_reg <= '0;
      out_imm_reg      <= '0;
    end else if (issue) begin
      out_valid_reg    <= 1'b1;
      out_addr_reg     <= head_addr;
      out_type_reg     <= d_type;
      out_mem_reg      <= d_mem;
      out_op_reg       <= d_op;
      out_dest_reg     <= d_dest;
      out_src1_reg     <= d_src1;
      out_src2_reg     <= d_src2;
      out_rs1_data_reg <= reg_rd1_data;
      out_rs2_data_reg <= reg_rd2_data;
      out_imm_reg      <= d_imm;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_addr       = out_addr_reg;
  assign out_instr_type = out_type_reg;
  assign out_mem_type   = out_mem_reg;
  assign out_op         = out_op_reg;
  assign out_dest       = out_dest_reg;
  assign out_src1       = out_src1_reg;
  assign out_src2       = out_src2_reg;
  assign out_rs1_data   = out_rs1_data_reg;
  assign out_rs2_data   = out_rs2_data_reg;
  assign out_imm        = out_imm_reg;
  assign illegal        = illegal_reg;
  assign occupancy      = count_reg;
endmodule
